// File: rtl/bcd_stopwatch_if.sv
// Button/level inputs and display outputs of the BCD stopwatch.
interface bcd_stopwatch_if;
  logic        start_stop;
  logic        clear;
  logic        dir;
  logic [15:0] data;
  logic        running;
  logic        wrap;

  modport master (
    output start_stop, clear, dir,
    input  data, running, wrap
  );

  modport slave (
    input  start_stop, clear, dir,
    output data, running, wrap
  );
endinterface

// File: rtl/bcd_stopwatch.sv
// Four-digit BCD up/down stopwatch with on-chip button synchronisers,
// debouncers, a run/stop FSM and a tick prescaler.
module bcd_stopwatch #(
  parameter int TICK_DIV   = 50000000,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic     clk,
  input  logic     rst_n,
  bcd_stopwatch_if.slave bus
);

  localparam int              DW        = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0]   DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [25:0]     TICK_LAST = 26'(TICK_DIV - 1);

  typedef enum logic {STOP, RUN} state_t;

  state_t        state_q, state_d;
  logic [1:0]    btn_s1, btn_s2, btn_deb, btn_prev, btn_evt;
  logic          dir_s1, dir_s2;
  logic [DW-1:0] deb_cnt [2];
  logic [25:0]   presc;
  logic [15:0]   data_q, data_next;
  logic          wrap_q, wrap_next;
  logic          carry;
  logic [3:0]    nib;
  logic          tick, ss_evt, clr_evt;

  // Bit 0 carries start/stop, bit 1 carries clear throughout the button path.
  assign ss_evt  = btn_evt[0];
  assign clr_evt = btn_evt[1];

  // Two-flop synchronisers for both buttons and the direction level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
      dir_s1 <= 1'b0;
      dir_s2 <= 1'b0;
    end else begin
      btn_s1 <= {bus.clear, bus.start_stop};
      btn_s2 <= btn_s1;
      dir_s1 <= bus.dir;
      dir_s2 <= dir_s1;
    end
  end

  // Debounce each button and register a one-cycle pulse on each rising debounced level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_deb  <= '0;
      btn_prev <= '0;
      btn_evt  <= '0;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      btn_prev <= btn_deb;
      btn_evt  <= btn_deb & ~btn_prev;
      for (int i = 0; i < 2; i++) begin
        if (btn_s2[i] == btn_deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          btn_deb[i] <= btn_s2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  // Run/stop state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= STOP;
    else        state_q <= state_d;
  end

  // Each start/stop press flips between STOP and RUN; clear never touches the state.
  always_comb begin
    state_d = state_q;
    if (ss_evt) state_d = (state_q == STOP) ? RUN : STOP;
  end

  assign tick = (state_q == RUN) && (presc == TICK_LAST);

  // Ripple BCD increment or decrement; a carry/borrow out of the top digit is the wrap.
  always_comb begin
    data_next = data_q;
    carry     = 1'b1;
    nib       = 4'd0;
    for (int i = 0; i < 4; i++) begin
      nib = data_q[4*i +: 4];
      if (carry) begin
        if (dir_s2) begin
          if (nib == 4'd9) begin
            data_next[4*i +: 4] = 4'd0;
          end else begin
            data_next[4*i +: 4] = nib + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (nib == 4'd0) begin
            data_next[4*i +: 4] = 4'd9;
          end else begin
            data_next[4*i +: 4] = nib - 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
    wrap_next = carry;
  end

  // Count register and prescaler; clear wins over a tick, and STOP freezes the prescaler.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
      presc  <= '0;
      wrap_q <= 1'b0;
    end else if (clr_evt) begin
      data_q <= '0;
      presc  <= '0;
      wrap_q <= 1'b0;
    end else if (state_q == RUN) begin
      if (tick) begin
        presc  <= '0;
        data_q <= data_next;
        wrap_q <= wrap_next;
      end else begin
        presc  <= presc + 26'd1;
        wrap_q <= 1'b0;
      end
    end else begin
      wrap_q <= 1'b0;
    end
  end

  assign bus.data    = data_q;
  assign bus.running = (state_q == RUN);
  assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Directed testbench for bcd_stopwatch: one slow instance (TICK_DIV=4) and
// one fast instance (TICK_DIV=1), both with DEB_CYCLES=2.
module tb_bcd_stopwatch;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  bcd_stopwatch_if if_main();
  bcd_stopwatch_if if_fast();

  bcd_stopwatch #(.TICK_DIV(4), .DEB_CYCLES(2)) u_main (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if_main)
  );

  bcd_stopwatch #(.TICK_DIV(1), .DEB_CYCLES(2)) u_fast (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if_fast)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached before the summary");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct {
    logic        ss;
    logic [15:0] exp_data;
    logic        exp_run;
  } vec_t;

  vec_t vecs [33];

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic stepEdge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic ss, input logic clr);
    if_main.start_stop = ss;
    if_main.clear      = clr;
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    to_bcd = {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  int   pts [9] = '{9, 10, 99, 100, 999, 1000, 9999, 10000, 10001};
  logic found;
  int   n;
  int   expv;

  initial begin
    // Edge-by-edge expectations for start, count, stop, hold and resume.
    vecs[ 0] = '{1'b1, 16'h0000, 1'b0};
    vecs[ 1] = '{1'b1, 16'h0000, 1'b0};
    vecs[ 2] = '{1'b1, 16'h0000, 1'b0};
    vecs[ 3] = '{1'b1, 16'h0000, 1'b0};
    vecs[ 4] = '{1'b1, 16'h0000, 1'b0};
    vecs[ 5] = '{1'b1, 16'h0000, 1'b1};
    vecs[ 6] = '{1'b1, 16'h0000, 1'b1};
    vecs[ 7] = '{1'b1, 16'h0000, 1'b1};
    vecs[ 8] = '{1'b0, 16'h0000, 1'b1};
    vecs[ 9] = '{1'b0, 16'h0001, 1'b1};
    vecs[10] = '{1'b0, 16'h0001, 1'b1};
    vecs[11] = '{1'b0, 16'h0001, 1'b1};
    vecs[12] = '{1'b0, 16'h0001, 1'b1};
    vecs[13] = '{1'b0, 16'h0002, 1'b1};
    vecs[14] = '{1'b0, 16'h0002, 1'b1};
    vecs[15] = '{1'b1, 16'h0002, 1'b1};
    vecs[16] = '{1'b1, 16'h0002, 1'b1};
    vecs[17] = '{1'b1, 16'h0003, 1'b1};
    vecs[18] = '{1'b0, 16'h0003, 1'b1};
    vecs[19] = '{1'b0, 16'h0003, 1'b1};
    vecs[20] = '{1'b0, 16'h0003, 1'b0};
    vecs[21] = '{1'b0, 16'h0003, 1'b0};
    vecs[22] = '{1'b0, 16'h0003, 1'b0};
    vecs[23] = '{1'b0, 16'h0003, 1'b0};
    vecs[24] = '{1'b0, 16'h0003, 1'b0};
    vecs[25] = '{1'b1, 16'h0003, 1'b0};
    vecs[26] = '{1'b1, 16'h0003, 1'b0};
    vecs[27] = '{1'b1, 16'h0003, 1'b0};
    vecs[28] = '{1'b0, 16'h0003, 1'b0};
    vecs[29] = '{1'b0, 16'h0003, 1'b0};
    vecs[30] = '{1'b0, 16'h0003, 1'b1};
    vecs[31] = '{1'b0, 16'h0004, 1'b1};
    vecs[32] = '{1'b0, 16'h0004, 1'b1};

    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0);
    if_main.dir        = 1'b1;
    if_fast.start_stop = 1'b0;
    if_fast.clear      = 1'b0;
    if_fast.dir        = 1'b1;

    // Reset held for three edges while both buttons toggle.
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if_main.start_stop = ~if_main.start_stop;
      if_main.clear      = ~if_main.clear;
      if_fast.start_stop = ~if_fast.start_stop;
      stepEdge();
    end
    checkOutput("reset main data", if_main.data, 16'h0000);
    checkOutput("reset main running", if_main.running, 1'b0);
    checkOutput("reset main wrap", if_main.wrap, 1'b0);
    checkOutput("reset fast data", if_fast.data, 16'h0000);
    checkOutput("reset fast running", if_fast.running, 1'b0);
    checkOutput("reset fast wrap", if_fast.wrap, 1'b0);

    applyStimulus(1'b0, 1'b0);
    if_fast.start_stop = 1'b0;
    rst_n = 1'b1;
    repeat (10) stepEdge();
    checkOutput("idle main data", if_main.data, 16'h0000);
    checkOutput("idle main running", if_main.running, 1'b0);
    checkOutput("idle fast data", if_fast.data, 16'h0000);
    checkOutput("idle fast running", if_fast.running, 1'b0);

    // Table: each vector drives the inputs ahead of edge i and checks after it.
    for (int i = 0; i < 33; i++) begin
      applyStimulus(vecs[i].ss, 1'b0);
      stepEdge();
      checkOutput($sformatf("table[%0d] data", i), if_main.data, vecs[i].exp_data);
      checkOutput($sformatf("table[%0d] running", i), if_main.running, vecs[i].exp_run);
      checkOutput($sformatf("table[%0d] wrap", i), if_main.wrap, 1'b0);
    end

    // Clear press while running at 0042; prescaler restarts from zero.
    found = 1'b0;
    for (int c = 0; c < 400 && !found; c++) begin
      stepEdge();
      if (if_main.data == 16'h0042) found = 1'b1;
    end
    checkOutput("reach 0042", found, 1'b1);
    for (int e = 1; e <= 10; e++) begin
      applyStimulus(1'b0, (e <= 3));
      stepEdge();
      if (e == 5) checkOutput("pre-clear data", if_main.data, 16'h0043);
      if (e == 6) begin
        checkOutput("clear data", if_main.data, 16'h0000);
        checkOutput("clear running", if_main.running, 1'b1);
        checkOutput("clear wrap", if_main.wrap, 1'b0);
      end
      if (e == 9)  checkOutput("post-clear hold", if_main.data, 16'h0000);
      if (e == 10) checkOutput("post-clear tick", if_main.data, 16'h0001);
    end

    // One-cycle start/stop glitch is ignored.
    applyStimulus(1'b1, 1'b0);
    stepEdge();
    applyStimulus(1'b0, 1'b0);
    repeat (8) stepEdge();
    checkOutput("glitch running", if_main.running, 1'b1);

    // Reset mid-run at 0317 with prescaler 2.
    found = 1'b0;
    for (int c = 0; c < 2000 && !found; c++) begin
      stepEdge();
      if (if_main.data == 16'h0317) found = 1'b1;
    end
    checkOutput("reach 0317", found, 1'b1);
    repeat (2) stepEdge();
    checkOutput("pre-reset data", if_main.data, 16'h0317);
    rst_n = 1'b0;
    stepEdge();
    checkOutput("midrun reset data", if_main.data, 16'h0000);
    checkOutput("midrun reset running", if_main.running, 1'b0);
    checkOutput("midrun reset wrap", if_main.wrap, 1'b0);
    rst_n = 1'b1;
    repeat (12) stepEdge();
    checkOutput("after reset data", if_main.data, 16'h0000);
    checkOutput("after reset running", if_main.running, 1'b0);

    // Fast instance counting up through every carry and the 9999 wrap.
    if_fast.dir        = 1'b1;
    if_fast.start_stop = 1'b1;
    for (int k = 0; k <= 10010; k++) begin
      if (k == 3) if_fast.start_stop = 1'b0;
      stepEdge();
      n = k - 5;
      if (k == 4 || k == 5) checkOutput($sformatf("up running k=%0d", k), if_fast.running, (k >= 5));
      for (int p = 0; p < 9; p++) begin
        if (n == pts[p]) begin
          checkOutput($sformatf("up data n=%0d", n), if_fast.data, to_bcd(n % 10000));
          checkOutput($sformatf("up wrap n=%0d", n), if_fast.wrap, (n == 10000));
        end
      end
    end

    // Fast instance counting down from 0000, then a clear coincident with a tick.
    rst_n = 1'b0;
    if_fast.dir = 1'b0;
    if_fast.start_stop = 1'b0;
    stepEdge();
    rst_n = 1'b1;
    for (int k = 0; k <= 27; k++) begin
      if_fast.start_stop = (k < 3);
      if_fast.clear      = (k >= 20 && k <= 22);
      stepEdge();
      if (k < 6)        expv = 0;
      else if (k <= 24) expv = (10000 - (k - 5)) % 10000;
      else if (k == 25) expv = 0;
      else              expv = 10000 - (k - 25);
      checkOutput($sformatf("down data k=%0d", k), if_fast.data, to_bcd(expv));
      checkOutput($sformatf("down wrap k=%0d", k), if_fast.wrap, (k == 6 || k == 26));
      checkOutput($sformatf("down running k=%0d", k), if_fast.running, (k >= 5));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
